fp64_to_int64_seq: RTL



---
 rtl/fp64_to_int64_seq_if.sv | 22 ++
 rtl/fp64_to_int64_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp64_to_int64_seq_if.sv
// Issue-side and result-side handshake bundle for the binary64 to int64/uint64 converter.
interface fp64_to_int64_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_unsigned;
  logic        in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_flags;

  modport master (
    output in_valid, in_data, in_unsigned, in_rm, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, in_unsigned, in_rm, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp64_to_int64_seq.sv
// Multi-cycle binary64 -> int64/uint64 converter (FCVT.L.D / FCVT.LU.D), 8-bit-per-cycle aligner.
// Optional macro FP2INT_RTZ_EN: honour in_rm (RTZ); otherwise every conversion rounds to nearest-even.
module fp64_to_int64_seq (
  input  logic               clk,
  input  logic               rst,
  fp64_to_int64_seq_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    SHIFT  = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [63:0] INT_MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT_MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] UINT_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef FP2INT_RTZ_EN
  localparam logic RTZ_EN = 1'b1;
`else
  localparam logic RTZ_EN = 1'b0;
`endif

  state_t             state_r, state_s;
  logic [63:0]        op_r, op_s;
  logic               uns_r, uns_s;
  logic               rm_r, rm_s;
  logic [63:0]        mag_r, mag_s;
  logic               guard_r, guard_s;
  logic               sticky_r, sticky_s;
  logic [5:0]         cnt_r, cnt_s;
  logic               right_r, right_s;
  logic               spec_r, spec_s;
  logic [1:0]         spec_flags_r, spec_flags_s;
  logic               out_valid_r, out_valid_s;
  logic [63:0]        out_data_r, out_data_s;
  logic [1:0]         out_flags_r, out_flags_s;

  logic               sign_s;
  logic [10:0]        exp_s;
  logic [51:0]        man_s;
  logic signed [11:0] e_s;
  logic               is_nan_s, is_inf_s, is_zero_s;
  logic               uk_special_s, uk_right_s;
  logic [63:0]        uk_result_s;
  logic [1:0]         uk_flags_s;
  logic [5:0]         uk_cnt_s;
  logic [5:0]         step_s;
  logic [63:0]        low_mask_s;
  logic               rm_eff_s, inc_s, nx_s;
  logic [64:0]        sum_s;
  logic [63:0]        rnd_data_s;
  logic [1:0]         rnd_flags_s;

  assign sign_s    = op_r[63];
  assign exp_s     = op_r[62:52];
  assign man_s     = op_r[51:0];
  // Subnormals share the minimum normal exponent so their right shift saturates at 54.
  assign e_s       = (exp_s == 11'd0) ? -12'sd1022 : ($signed({1'b0, exp_s}) - 12'sd1023);
  assign is_nan_s  = (exp_s == 11'h7FF) && (man_s != 52'd0);
  assign is_inf_s  = (exp_s == 11'h7FF) && (man_s == 52'd0);
  assign is_zero_s = (exp_s == 11'd0) && (man_s == 52'd0);

  assign step_s     = (cnt_r > 6'd8) ? 6'd8 : cnt_r;
  assign low_mask_s = (64'd1 << (step_s - 6'd1)) - 64'd1;

  assign rm_eff_s = rm_r & RTZ_EN;
  assign inc_s    = ~rm_eff_s & guard_r & (sticky_r | mag_r[0]);
  assign sum_s    = {1'b0, mag_r} + {64'd0, inc_s};
  assign nx_s     = guard_r | sticky_r;

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_flags = out_flags_r;

  // Classify the latched operand into a final special result or a normal alignment job.
  always_comb begin
    uk_special_s = 1'b1;
    uk_result_s  = 64'd0;
    uk_flags_s   = 2'b00;
    if (is_nan_s) begin
      uk_result_s = uns_r ? UINT_MAX : INT_MAX;
      uk_flags_s  = 2'b10;
    end else if (is_inf_s) begin
      if (uns_r) begin
        uk_result_s = sign_s ? 64'd0 : UINT_MAX;
      end else begin
        uk_result_s = sign_s ? INT_MIN : INT_MAX;
      end
      uk_flags_s = 2'b10;
    end else if (is_zero_s) begin
      uk_result_s = 64'd0;
      uk_flags_s  = 2'b00;
    end else if (!uns_r && (e_s >= 12'sd63)) begin
      if (sign_s && (op_r[62:0] == 63'h43E0_0000_0000_0000)) begin
        uk_result_s = INT_MIN;
        uk_flags_s  = 2'b00;
      end else begin
        uk_result_s = sign_s ? INT_MIN : INT_MAX;
        uk_flags_s  = 2'b10;
      end
    end else if (uns_r && (e_s >= 12'sd64)) begin
      uk_result_s = sign_s ? 64'd0 : UINT_MAX;
      uk_flags_s  = 2'b10;
    end else begin
      uk_special_s = 1'b0;
    end
  end

  // Choose shift direction and distance for the aligner.
  always_comb begin
    if (e_s >= 12'sd52) begin
      uk_right_s = 1'b0;
      uk_cnt_s   = 6'(e_s - 12'sd52);
    end else if (e_s < -12'sd2) begin
      uk_right_s = 1'b1;
      uk_cnt_s   = 6'd54;
    end else begin
      uk_right_s = 1'b1;
      uk_cnt_s   = 6'(12'sd52 - e_s);
    end
  end

  // Rounded result with saturation and sign application.
  always_comb begin
    rnd_data_s  = 64'd0;
    rnd_flags_s = 2'b00;
    if (spec_r) begin
      rnd_data_s  = mag_r;
      rnd_flags_s = spec_flags_r;
    end else if (uns_r) begin
      if (sign_s) begin
        rnd_data_s  = 64'd0;
        rnd_flags_s = (sum_s != 65'd0) ? 2'b10 : {1'b0, nx_s};
      end else if (sum_s[64]) begin
        rnd_data_s  = UINT_MAX;
        rnd_flags_s = 2'b10;
      end else begin
        rnd_data_s  = sum_s[63:0];
        rnd_flags_s = {1'b0, nx_s};
      end
    end else begin
      if (sign_s) begin
        if (sum_s > {1'b0, INT_MIN}) begin
          rnd_data_s  = INT_MIN;
          rnd_flags_s = 2'b10;
        end else begin
          rnd_data_s  = 64'd0 - sum_s[63:0];
          rnd_flags_s = {1'b0, nx_s};
        end
      end else if (sum_s[64] | sum_s[63]) begin
        rnd_data_s  = INT_MAX;
        rnd_flags_s = 2'b10;
      end else begin
        rnd_data_s  = sum_s[63:0];
        rnd_flags_s = {1'b0, nx_s};
      end
    end
  end

  // Next-state logic and output-valid decode.
  always_comb begin
    state_s     = state_r;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = UNPACK;
        end else begin
          state_s = IDLE;
        end
      end
      UNPACK: begin
        if (uk_special_s || (uk_cnt_s == 6'd0)) begin
          state_s = ROUND;
        end else begin
          state_s = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_r <= 6'd8) begin
          state_s = ROUND;
        end else begin
          state_s = SHIFT;
        end
      end
      ROUND: state_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
    out_valid_s = (state_s == DONE);
  end

  // Datapath next values: operand latch, unpack, one aligner step, rounding capture.
  always_comb begin
    op_s         = op_r;
    uns_s        = uns_r;
    rm_s         = rm_r;
    mag_s        = mag_r;
    guard_s      = guard_r;
    sticky_s     = sticky_r;
    cnt_s        = cnt_r;
    right_s      = right_r;
    spec_s       = spec_r;
    spec_flags_s = spec_flags_r;
    out_data_s   = out_data_r;
    out_flags_s  = out_flags_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          op_s  = bus.in_data;
          uns_s = bus.in_unsigned;
          rm_s  = bus.in_rm;
        end else begin
          op_s = op_r;
        end
      end
      UNPACK: begin
        guard_s      = 1'b0;
        sticky_s     = 1'b0;
        spec_s       = uk_special_s;
        spec_flags_s = uk_flags_s;
        right_s      = uk_right_s;
        if (uk_special_s) begin
          mag_s = uk_result_s;
          cnt_s = 6'd0;
        end else begin
          mag_s = {11'd0, (exp_s != 11'd0), man_s};
          cnt_s = uk_cnt_s;
        end
      end
      SHIFT: begin
        cnt_s = cnt_r - step_s;
        if (right_r) begin
          mag_s    = mag_r >> step_s;
          guard_s  = mag_r[step_s - 6'd1];
          sticky_s = sticky_r | guard_r | (|(mag_r & low_mask_s));
        end else begin
          mag_s = mag_r << step_s;
        end
      end
      ROUND: begin
        out_data_s  = rnd_data_s;
        out_flags_s = rnd_flags_s;
      end
      DONE:    out_data_s = out_data_r;
      default: out_data_s = out_data_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r         <= 64'd0;
      uns_r        <= 1'b0;
      rm_r         <= 1'b0;
      mag_r        <= 64'd0;
      guard_r      <= 1'b0;
      sticky_r     <= 1'b0;
      cnt_r        <= 6'd0;
      right_r      <= 1'b0;
      spec_r       <= 1'b0;
      spec_flags_r <= 2'b00;
      out_valid_r  <= 1'b0;
      out_data_r   <= 64'd0;
      out_flags_r  <= 2'b00;
    end else begin
      op_r         <= op_s;
      uns_r        <= uns_s;
      rm_r         <= rm_s;
      mag_r        <= mag_s;
      guard_r      <= guard_s;
      sticky_r     <= sticky_s;
      cnt_r        <= cnt_s;
      right_r      <= right_s;
      spec_r       <= spec_s;
      spec_flags_r <= spec_flags_s;
      out_valid_r  <= out_valid_s;
      out_data_r   <= out_data_s;
      out_flags_r  <= out_flags_s;
    end
  end
endmodule
